seq_adder: RTL

SEQ_ADDER -- requirements
Module: seq_adder

---
 rtl/adder_pkg.sv | 19 +
 rtl/ripple_adder.sv | 38 +++
 rtl/seq_adder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the sequential chunked adder:
//   state_t     - FSM encoding used by seq_adder (IDLE, BUSY, DONE)
//   DEF_WIDTH   - default operand/result width in bits
//   DEF_CHUNK   - default number of bits added per BUSY cycle
// ---------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

endpackage : adder_pkg

// File: rtl/ripple_adder.sv
// ---------------------------------------------------------------------------
// ripple_adder
// Purely combinational W-bit ripple-carry adder.
// Ports:
//   a, b   in  [W-1:0]  operands
//   ci     in           carry-in
//   s      out [W-1:0]  sum
//   co     out          carry out of the MSB
//   c_msb  out          carry into the MSB (for signed overflow detection)
// ---------------------------------------------------------------------------
module ripple_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);

   // NOTE: the carry is a local variable updated with blocking assignments so
   // each loop iteration sees the previous bit's carry; every output gets a
   // default first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      logic carry;
      carry = ci;
      s     = '0;
      c_msb = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) c_msb = carry;
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule : ripple_adder

// File: rtl/seq_adder.sv
// ---------------------------------------------------------------------------
// seq_adder
// Multi-cycle adder: operands are captured on a valid/ready handshake and
// summed CHUNK bits per cycle through a single CHUNK-wide ripple_adder.
// The result is presented with out_valid until the consumer takes it.
// Optional feature (macro ADDER_SUB_EN): adds input `sub`; when set, the
// block computes a + ~b + 1 (ci ignored), and co=1 means "no borrow".
// Ports:
//   clk        in            clock, all state on rising edge
//   rst        in            asynchronous active-high reset
//   in_valid   in            a, b, ci (and sub) valid
//   in_ready   out           block is IDLE and can accept operands
//   a, b       in  [WIDTH]   operands
//   ci         in            carry-in
//   sub        in            subtract select (only with ADDER_SUB_EN)
//   out_valid  out           sum, co, ovf valid (DONE state)
//   out_ready  in            consumer accepts the result
//   sum        out [WIDTH]   result
//   co         out           unsigned carry-out
//   ovf        out           two's-complement overflow
// ---------------------------------------------------------------------------
module seq_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [IDX_W-1:0] idx;

   logic [CHUNK-1:0] chunk_s;
   logic             chunk_co;
   logic             chunk_cmsb;

   ripple_adder #(.W(CHUNK)) u_ripple (
      .a     (a_r[idx*CHUNK +: CHUNK]),
      .b     (b_r[idx*CHUNK +: CHUNK]),
      .ci    (carry_r),
      .s     (chunk_s),
      .co    (chunk_co),
      .c_msb (chunk_cmsb)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // NOTE: every register, including the captured operands, is reset so an
   // aborted operation leaves no stale data behind; state uses <= only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r <= a;
                  idx <= '0;
`ifdef ADDER_SUB_EN
                  // Subtraction is a + ~b + 1: invert b once at capture and
                  // seed the carry with 1 so the datapath stays an adder.
                  b_r     <= sub ? ~b : b;
                  carry_r <= sub ? 1'b1 : ci;
`else
                  b_r     <= b;
                  carry_r <= ci;
`endif
                  state <= BUSY;
               end
            end
            BUSY: begin
               sum[idx*CHUNK +: CHUNK] <= chunk_s;
               carry_r                 <= chunk_co;
               if (idx == LAST_IDX) begin
                  co    <= chunk_co;
                  ovf   <= chunk_cmsb ^ chunk_co;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : seq_adder
